ds2by2_window_gen: RTL and testbench
====================================

# ds2by2_window_gen

Builds 2×2 windows for the downsampling (max-pool) stage from a raster-order pixel stream. It buffers each even row and pairs it with the following odd row. It emits one non-overlapping stride-2 window per 2×2 block, shaped to drive the 2×2 downsampling unit's `IN[1:0][1:0]` input directly. It sits between the feature-map stream source and the downsampling unit, and runs at one input pixel per cycle when not back-pressured.

## Interface
- `BITS`, 8, pixel width in bits.
- `WIDTH`, 28, pixels per row. Must be even and ≥ 2; elaboration-time assertion.
- `HEIGHT`, 28, rows per frame. Must be even and ≥ 2; elaboration-time assertion.

Ports (clock and reset first):
- `clk` input 1: the single clock.
- `rst_n` input 1: reset, synchronous and active-low.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: the block accepts `in_data` this cycle.
- `in_data` input `BITS`: pixel, raster order, row-major.
- `win_valid` output 1: `win_data` holds a window.
- `win_ready` input 1: downstream accepts the window.
- `win_data` output `[BITS-1:0] [1:0][1:0]`: `[0][0]` top-left, `[0][1]` top-right, `[1][0]` bottom-left, `[1][1]` bottom-right.
- `win_last` output 1: qualifies `win_data` as the final window of the frame.

## Operation
- Beat: input transfer when `in_valid && in_ready`. Window transfer when `win_valid && win_ready`.
- Counters:
  - `col` runs 0..`WIDTH`-1 and `row` runs 0..`HEIGHT`-1. Both advance only on an input beat.
  - `col` wraps to 0 and increments `row`. `row` wraps to 0 after the last pixel of the frame.
- Even row: the pixel is written to `row_buf[col]`. No output is produced.
- Odd row, even col: the pixel is captured into the `left_pix` register.
- Odd row, odd col (completing beat): the output register loads:
  - `[0][0]=row_buf[col-1]`, `[0][1]=row_buf[col]`
  - `[1][0]=left_pix`, `[1][1]=in_data`
  - `win_valid` is set.
  - `win_last` is set iff `row==HEIGHT-1 && col==WIDTH-1`.
- Flow control: `in_ready = !win_valid || win_ready`, combinational. A beat is never dropped. The output register can never be overwritten while it holds an unaccepted window.
- `win_valid` clears on a window transfer, unless the same cycle's input beat is a completing beat; in that case the new window loads and `win_valid` stays 1.
- Output stability: while `win_valid && !win_ready`, `win_data` and `win_last` hold.
- Reset, including mid-frame:
  - `col`, `row`, `win_valid`, `win_last` go to 0. `win_data` goes to 0. `in_ready` reads 1 after reset.
  - A partial frame is discarded. The next accepted pixel is (row 0, col 0).
  - `row_buf` and `left_pix` are not reset. Their contents are don't-care until rewritten.
- Frames are back-to-back with no gap: the pixel after the last pixel of a frame is (0,0) of the next frame.
- Windows per frame: exactly (`WIDTH`/2)·(`HEIGHT`/2).

## Timing
- Latency: `win_valid` rises the cycle after the completing input beat (1 cycle).
- Throughput: 1 pixel/cycle sustained when `win_ready` is held 1. Windows appear every 2nd cycle during odd rows and never during even rows.
- Backpressure stalls input only while a window is pending and `win_ready=0`.
- The output register is a single stage with no skid buffer. The `in_ready` → `win_ready` combinational path is accepted.
- All state updates on the rising edge of `clk`. Reset takes effect on the edge where `rst_n=0`.

## Structure
- Shared package `ds_pkg`:
  - `pixel_t` (logic [BITS-1:0] at package default 8)
  - `window_t` (pixel_t [1:0][1:0])
  - localparams `DS_WIN=2`, `DS_STRIDE=2`.
- One sub-module: `ds_row_buffer`. It holds `WIDTH`×`BITS` storage with one write port (`we`, `waddr`) and two combinational read ports (`raddr`, `raddr|1` pair at even/odd address). It has no reset on storage.
- Counters, `left_pix`, flow control and the output register live in `ds2by2_window_gen`.

## Test plan
- `WIDTH=4`, `HEIGHT=4`, pixel = 4·r+c, `in_valid` and `win_ready` held 1. Required response:
  - Windows `{0,1,4,5}`, `{2,3,6,7}`, `{8,9,12,13}`, `{10,11,14,15}`, in `[0][0],[0][1],[1][0],[1][1]` order.
  - `win_last` set only on the 4th window.
  - Each window appears 1 cycle after pixels 5, 7, 13 and 15 respectively.
- Same frame, `win_ready=0` for 5 cycles when `{2,3,6,7}` appears. Required response:
  - `win_data` holds.
  - `in_ready=0` only in those cycles.
  - Pixel 8 is not lost. Subsequent windows are unchanged.
- Random `in_valid` gaps and random `win_ready`, over 3 back-to-back frames at 28×28 with pixel=(r+c)%256. Required response: the scoreboard matches 196 windows per frame, exactly 3 `win_last` pulses, and no duplicates.
- Assert `rst_n=0` for 1 cycle after pixel 6 of a 4×4 frame, then restart from pixel 0. Required response:
  - Outputs are 0 during reset.
  - No window is emitted containing pre-reset data.
  - Afterwards, the full 4-window sequence is correct.
- `WIDTH=2`, `HEIGHT=2`, pixels `{255,0,7,255}`. Required response: a single window `{255,0,7,255}` with `win_last=1`. This window, fed to the 2×2 downsampler, gives 255.

Source files
------------

// File: rtl/ds_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ds_pkg
// Shared types and constants for the 2x2 stride-2 downsampling path.
// Revision: 1.0
// ---------------------------------------------------------------------------
package ds_pkg;

  localparam int PIXEL_BITS = 8;
  localparam int DS_WIN     = 2;
  localparam int DS_STRIDE  = 2;

  typedef logic [PIXEL_BITS-1:0] pixel_t;
  typedef pixel_t [DS_WIN-1:0][DS_WIN-1:0] window_t;

endpackage
`default_nettype wire

// File: rtl/ds_row_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ds_row_buffer
// One-row pixel store: single write port, paired combinational read of the
// even/odd column pair that contains raddr. Storage is not reset.
// Revision: 1.0
// ---------------------------------------------------------------------------
module ds_row_buffer #(
  parameter int BITS  = 8,
  parameter int WIDTH = 28,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [BITS-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [BITS-1:0] rdata_even,
  output logic [BITS-1:0] rdata_odd
);

  logic [BITS-1:0] mem [WIDTH];
  logic [AW-1:0]   addr_even;
  logic [AW-1:0]   addr_odd;

  // Pair addresses: force bit 0 low/high so one lookup serves a stride-2 column pair.
  always_comb begin
    addr_even = raddr & ~AW'(1);
    addr_odd  = raddr |  AW'(1);
  end

  // Write port; no reset so the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_even = mem[addr_even];
  assign rdata_odd  = mem[addr_odd];

endmodule
`default_nettype wire

// File: rtl/ds2by2_window_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ds2by2_window_gen
// Turns a raster pixel stream into non-overlapping 2x2 windows for the
// max-pool unit. Even rows are buffered; odd rows pair with the buffer.
// Revision: 1.0
// ---------------------------------------------------------------------------
module ds2by2_window_gen
  import ds_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 28
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [BITS-1:0]                             in_data,
  output logic                                        win_valid,
  input  logic                                        win_ready,
  output logic [DS_WIN-1:0][DS_WIN-1:0][BITS-1:0]     win_data,
  output logic                                        win_last
);

  localparam int AW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  // Geometry must tile exactly into stride-2 blocks.
  if ((WIDTH < DS_WIN) || (WIDTH % DS_STRIDE != 0)) begin : g_chk_width
    $error("ds2by2_window_gen: WIDTH must be even and >= 2");
  end
  if ((HEIGHT < DS_WIN) || (HEIGHT % DS_STRIDE != 0)) begin : g_chk_height
    $error("ds2by2_window_gen: HEIGHT must be even and >= 2");
  end

  logic [AW-1:0]   col;
  logic [RW-1:0]   row;
  logic [BITS-1:0] left_pix;
  logic [BITS-1:0] buf_even;
  logic [BITS-1:0] buf_odd;
  logic            in_beat;
  logic            col_last;
  logic            row_last;
  logic            buf_we;
  logic            complete;

  // Handshake and beat classification; odd row + odd col closes a 2x2 block.
  always_comb begin
    in_ready = !win_valid || win_ready;
    in_beat  = in_valid && in_ready;
    col_last = (col == AW'(WIDTH - 1));
    row_last = (row == RW'(HEIGHT - 1));
    buf_we   = in_beat && !row[0];
    complete = in_beat && row[0] && col[0];
  end

  ds_row_buffer #(
    .BITS  (BITS),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_row_buffer (
    .clk        (clk),
    .we         (buf_we),
    .waddr      (col),
    .wdata      (in_data),
    .raddr      (col),
    .rdata_even (buf_even),
    .rdata_odd  (buf_odd)
  );

  // Raster position; advances only on accepted pixels, frames run back to back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (in_beat) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + AW'(1);
      end
    end
  end

  // Bottom-left pixel of the current block, held until its partner arrives.
  always_ff @(posedge clk) begin
    if (in_beat && row[0] && !col[0]) left_pix <= in_data;
  end

  // Single-stage output register; a completing beat can only occur when the
  // register is free or draining this cycle, so nothing is overwritten.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_data  <= '0;
    end else if (complete) begin
      win_valid      <= 1'b1;
      win_last       <= row_last && col_last;
      win_data[0][0] <= buf_even;
      win_data[0][1] <= buf_odd;
      win_data[1][0] <= left_pix;
      win_data[1][1] <= in_data;
    end else if (win_valid && win_ready) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ds2by2_window_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ds2by2_window_gen
// Self-checking bench: three geometries (4x4, 28x28, 2x2) against a
// block-level window model and a pending-window handshake model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_ds2by2_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n     [3];
  logic                 in_valid  [3];
  logic                 in_ready  [3];
  logic [7:0]           in_data   [3];
  logic                 win_valid [3];
  logic                 win_ready [3];
  logic [1:0][1:0][7:0] win_data  [3];
  logic                 win_last  [3];

  ds2by2_window_gen #(.BITS(8), .WIDTH(4), .HEIGHT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .win_valid(win_valid[0]), .win_ready(win_ready[0]),
    .win_data(win_data[0]), .win_last(win_last[0]));

  ds2by2_window_gen #(.BITS(8), .WIDTH(28), .HEIGHT(28)) u_dut28 (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .win_valid(win_valid[1]), .win_ready(win_ready[1]),
    .win_data(win_data[1]), .win_last(win_last[1]));

  ds2by2_window_gen #(.BITS(8), .WIDTH(2), .HEIGHT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .win_valid(win_valid[2]), .win_ready(win_ready[2]),
    .win_data(win_data[2]), .win_last(win_last[2]));

  typedef struct {
    logic [1:0][1:0][7:0] w;
    bit                   last;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixel value generators: 0 -> 4r+c, 1 -> (r+c)%256, 2 -> fixed 2x2 table.
  function automatic logic [7:0] pix(input int mode, input int r, input int c, input int w);
    int idx;
    idx = r * w + c;
    case (mode)
      0:       return 8'(4 * r + c);
      1:       return 8'((r + c) % 256);
      default: case (idx)
                 0:       return 8'd255;
                 1:       return 8'd0;
                 2:       return 8'd7;
                 default: return 8'd255;
               endcase
    endcase
  endfunction

  // Drives nfr frames into instance d (optionally truncated to max_beats pixels)
  // and checks every cycle against the block model.
  task automatic run(input int d, input int W, input int H, input int nfr, input int mode,
                     input bit rnd, input int stall_win, input int max_beats, input string tag);
    int  npix, fed, got, lasts, exp_lasts, exp_total, pend, stall_left, budget;
    int  r, c, idx, base;
    bit  iv, wr, rdy_m;
    exp_t e;

    npix = W * H * nfr;
    if (max_beats >= 0 && max_beats < npix) npix = max_beats;

    // Expected windows: one per 2x2 block, in block raster order, only if its
    // bottom-right pixel is within the pixels that will be sent.
    exp_q.delete();
    exp_total = 0;
    exp_lasts = 0;
    for (int f = 0; f < nfr; f++) begin
      for (int br = 0; br < H / 2; br++) begin
        for (int bc = 0; bc < W / 2; bc++) begin
          base = f * W * H + (2 * br + 1) * W + 2 * bc + 1;
          if (base < npix) begin
            e.w[0][0] = pix(mode, 2 * br,     2 * bc,     W);
            e.w[0][1] = pix(mode, 2 * br,     2 * bc + 1, W);
            e.w[1][0] = pix(mode, 2 * br + 1, 2 * bc,     W);
            e.w[1][1] = pix(mode, 2 * br + 1, 2 * bc + 1, W);
            e.last    = (br == H / 2 - 1) && (bc == W / 2 - 1);
            exp_q.push_back(e);
            exp_total++;
            if (e.last) exp_lasts++;
          end
        end
      end
    end

    fed = 0; got = 0; lasts = 0; pend = 0; stall_left = 5;
    budget = npix * 20 + 200;
    while ((fed < npix || pend > 0) && budget > 0) begin
      @(negedge clk);
      idx = fed % (W * H);
      r   = idx / W;
      c   = idx % W;
      iv  = (fed < npix) && (!rnd || ($urandom_range(0, 3) != 0));
      wr  = !rnd || ($urandom_range(0, 2) != 0);
      if (stall_win == got && pend > 0 && stall_left > 0) begin
        wr = 1'b0;
        stall_left--;
      end
      in_valid[d]  = iv;
      in_data[d]   = iv ? pix(mode, r, c, W) : 8'hxx;
      win_ready[d] = wr;
      #1;
      rdy_m = (pend == 0) || wr;
      chk({tag, ".in_ready"},  64'(in_ready[d]),  64'(rdy_m));
      chk({tag, ".win_valid"}, 64'(win_valid[d]), 64'(pend > 0));
      if (pend > 0 && exp_q.size() > 0) begin
        chk({tag, ".win_data"}, 64'(win_data[d]), 64'(exp_q[0].w));
        chk({tag, ".win_last"}, 64'(win_last[d]), 64'(exp_q[0].last));
      end
      if (pend > 0 && wr) begin
        if (exp_q.size() > 0) begin
          if (exp_q[0].last) lasts++;
          void'(exp_q.pop_front());
        end
        got++;
        pend--;
      end
      if (iv && rdy_m) begin
        if ((r % 2 == 1) && (c % 2 == 1)) pend++;
        fed++;
      end
      budget--;
    end
    @(negedge clk);
    in_valid[d]  = 1'b0;
    win_ready[d] = 1'b0;
    chk({tag, ".budget"},  64'(budget > 0), 64'(1));
    chk({tag, ".windows"}, 64'(got),        64'(exp_total));
    chk({tag, ".lasts"},   64'(lasts),      64'(exp_lasts));
  endtask

  task automatic chk_reset_state(input int d, input string tag);
    chk({tag, ".rst.win_valid"}, 64'(win_valid[d]), 64'(0));
    chk({tag, ".rst.win_last"},  64'(win_last[d]),  64'(0));
    chk({tag, ".rst.win_data"},  64'(win_data[d]),  64'(0));
    chk({tag, ".rst.in_ready"},  64'(in_ready[d]),  64'(1));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i]     = 1'b0;
      in_valid[i]  = 1'b0;
      in_data[i]   = 8'h00;
      win_ready[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    #1;
    chk_reset_state(0, "dut4");
    chk_reset_state(1, "dut28");
    chk_reset_state(2, "dut2");
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // 4x4 streaming, full throughput.
    run(0, 4, 4, 1, 0, 1'b0, -1, -1, "stream4");

    // 4x4 with 5-cycle backpressure on the second window.
    run(0, 4, 4, 1, 0, 1'b0, 1, -1, "stall4");

    // Reset after pixel 6, then a clean frame.
    run(0, 4, 4, 1, 0, 1'b0, -1, 7, "pre_rst4");
    @(negedge clk);
    rst_n[0]     = 1'b0;
    in_valid[0]  = 1'b0;
    win_ready[0] = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_state(0, "midrst4");
    rst_n[0]     = 1'b1;
    win_ready[0] = 1'b0;
    run(0, 4, 4, 1, 0, 1'b0, -1, -1, "post_rst4");

    // 28x28, three back-to-back frames, random gaps on both sides.
    run(1, 28, 28, 3, 1, 1'b1, -1, -1, "rand28");

    // 2x2 single-window frame.
    run(2, 2, 2, 1, 2, 1'b0, -1, -1, "tiny2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
